// File: rtl/veririsc_pkg.sv
// Shared types for the VeriRISC sequencer: opcode and phase encodings plus ALU-opcode classification.
// The optional single-step build is selected by VERIRISC_SEQ_SINGLE_STEP_EN in the files that import this package.
package veririsc_pkg;

   typedef enum logic [2:0] {
      HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
   } phase_t;

   // Opcodes that read an operand from memory and update the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/veririsc_phase_gen.sv
// Phase counter for the VeriRISC sequencer with halt capture.
// With VERIRISC_SEQ_SINGLE_STEP_EN defined, phase 0 waits for a rising edge on step_i.
module veririsc_phase_gen
   import veririsc_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic   clk_i,
   input  logic   rst_ni,
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
   input  logic   step_i,
`endif
   input  logic   halt_req_i,
   output phase_t phase_o,
   output logic   halted_o
);

   phase_t phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   run;

`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
   logic step_prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) step_prev_q <= 1'b0;
      else         step_prev_q <= step_i;
   end

   // Only the fetch boundary waits for a step; phases 1..7 always run through.
   assign run = (phase_q != INST_ADDR) || (step_i && !step_prev_q);
`else
   assign run = 1'b1;
`endif

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (HALT_STICKY && halt_req_i) halted_d = 1'b1;
         else if (run)                  phase_d  = phase_t'(phase_q + 3'd1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   assign phase_o  = phase_q;
   assign halted_o = halted_q;

endmodule

// File: rtl/veririsc_sequencer.sv
// VeriRISC instruction-cycle controller: decodes phase and opcode into datapath strobes.
// Define VERIRISC_SEQ_SINGLE_STEP_EN to add the step input for one-instruction-per-pulse operation.
module veririsc_sequencer
   import veririsc_pkg::*;
#(
   parameter bit HALT_STICKY  = 1'b1,
   parameter int OPCODE_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
   input  logic                    step,
`endif
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output logic [2:0]              phase,
   output logic                    sel,
   output logic                    mem_rd,
   output logic                    load_ir,
   output logic                    halt,
   output logic                    inc_pc,
   output logic                    load_ac,
   output logic                    load_pc,
   output logic                    mem_wr,
   output logic                    data_e
);

   if (OPCODE_WIDTH != 3) begin : g_width_check
      $error("veririsc_sequencer supports OPCODE_WIDTH = 3 only");
   end

   opcode_t op;
   phase_t  cur_phase;
   logic    halted;
   logic    alu;
   logic    halt_req;

   assign op       = opcode_t'(opcode);
   assign alu      = is_aluop(op);
   assign halt_req = (cur_phase == OP_ADDR) && (op == HLT);

   veririsc_phase_gen #(
      .HALT_STICKY (HALT_STICKY)
   ) u_phase_gen (
      .clk_i      (clk),
      .rst_ni     (reset),
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
      .step_i     (step),
`endif
      .halt_req_i (halt_req),
      .phase_o    (cur_phase),
      .halted_o   (halted)
   );

   assign phase = cur_phase;

   // Opcode is only consulted in phases 4..7 so an unsettled IR cannot leak into fetch strobes.
   always_comb begin
      sel     = 1'b0;
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      data_e  = 1'b0;
      unique case (cur_phase)
         INST_ADDR: sel = 1'b1;
         INST_FETCH: begin
            sel    = 1'b1;
            mem_rd = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel     = 1'b1;
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (op == HLT);
         end
         OP_FETCH: mem_rd = alu;
         ALU_OP: begin
            mem_rd  = alu;
            inc_pc  = (op == SKZ) && zero;
            load_pc = (op == JMP);
            data_e  = (op == STO);
         end
         STORE: begin
            mem_rd  = alu;
            inc_pc  = (op == JMP);
            load_ac = alu;
            load_pc = (op == JMP);
            mem_wr  = (op == STO);
            data_e  = (op == STO);
         end
         default: ;
      endcase
      if (halted) begin
         sel     = 1'b0;
         mem_rd  = 1'b0;
         load_ir = 1'b0;
         halt    = 1'b1;
         inc_pc  = 1'b0;
         load_ac = 1'b0;
         load_pc = 1'b0;
         mem_wr  = 1'b0;
         data_e  = 1'b0;
      end
   end

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Self-checking bench for veririsc_sequencer: a sticky-halt and a pulse-halt instance against an instruction-level model.
// Exercises the step input when VERIRISC_SEQ_SINGLE_STEP_EN is defined.
module tb_veririsc_sequencer;

   localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_STO = 3'd6, OP_JMP = 3'd7;

   logic       clk;
   logic       reset;
   logic       step;
   logic       autoStep;
   logic [2:0] opcode;
   logic       zero;
   logic       checkEn;
   int         numChecks;
   int         numFails;

   logic [2:0] phaseS, phaseP;
   logic selS, memRdS, loadIrS, haltS, incPcS, loadAcS, loadPcS, memWrS, dataES;
   logic selP, memRdP, loadIrP, haltP, incPcP, loadAcP, loadPcP, memWrP, dataEP;

   veririsc_sequencer #(.HALT_STICKY(1'b1), .OPCODE_WIDTH(3)) dutS (
      .clk(clk), .reset(reset),
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .opcode(opcode), .zero(zero), .phase(phaseS),
      .sel(selS), .mem_rd(memRdS), .load_ir(loadIrS), .halt(haltS), .inc_pc(incPcS),
      .load_ac(loadAcS), .load_pc(loadPcS), .mem_wr(memWrS), .data_e(dataES)
   );

   veririsc_sequencer #(.HALT_STICKY(1'b0), .OPCODE_WIDTH(3)) dutP (
      .clk(clk), .reset(reset),
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .opcode(opcode), .zero(zero), .phase(phaseP),
      .sel(selP), .mem_rd(memRdP), .load_ir(loadIrP), .halt(haltP), .inc_pc(incPcP),
      .load_ac(loadAcP), .load_pc(loadPcP), .mem_wr(memWrP), .data_e(dataEP)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (autoStep) begin
            #1 step = ~step;
         end
      end
   end

   // Instruction-level model: one slot per instance (0 = sticky halt, 1 = pulse halt).
   logic [2:0] mPhase [2];
   logic       mHalted [2];
   logic       mStepPrev;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mPhase[i]  <= 3'd0;
            mHalted[i] <= 1'b0;
         end
         mStepPrev <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!mHalted[i]) begin
               if (i == 0 && mPhase[i] == 3'd4 && opcode == OP_HLT)
                  mHalted[i] <= 1'b1;
`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
               else if (mPhase[i] != 3'd0 || (step && !mStepPrev))
`else
               else
`endif
                  mPhase[i] <= mPhase[i] + 3'd1;
            end
         end
         mStepPrev <= step;
      end
   end

   // Expected {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e}.
   function automatic logic [8:0] expectVec(input logic [2:0] p, input logic [2:0] op,
                                            input logic z, input logic h);
      logic alu;
      if (h) return 9'b0_0010_0000;
      alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      return { p < 3'd4,
               (p >= 3'd1 && p <= 3'd3) || (p >= 3'd5 && alu),
               p == 3'd2 || p == 3'd3,
               p == 3'd4 && op == OP_HLT,
               p == 3'd4 || (p == 3'd6 && op == OP_SKZ && z) || (p == 3'd7 && op == OP_JMP),
               p == 3'd7 && alu,
               p >= 3'd6 && op == OP_JMP,
               p == 3'd7 && op == OP_STO,
               p >= 3'd6 && op == OP_STO };
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("sticky phase", 32'(phaseS), 32'(mPhase[0]));
         checkOutput("sticky strobes",
                     32'({selS, memRdS, loadIrS, haltS, incPcS, loadAcS, loadPcS, memWrS, dataES}),
                     32'(expectVec(mPhase[0], opcode, zero, mHalted[0])));
         checkOutput("pulse phase", 32'(phaseP), 32'(mPhase[1]));
         checkOutput("pulse strobes",
                     32'({selP, memRdP, loadIrP, haltP, incPcP, loadAcP, loadPcP, memWrP, dataEP}),
                     32'(expectVec(mPhase[1], opcode, zero, 1'b0)));
      end
   end

   task automatic applyStimulus(input logic [2:0] op, input logic z);
      #1;
      opcode = op;
      zero   = z;
   endtask

   task automatic waitPhase(input logic [2:0] target);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (phaseS == target) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("wait for phase", 32'(found), 32'd1);
   endtask

   // Run one instruction from phase 0 and record each strobe as a bit per phase.
   task automatic runInstr(input logic [2:0] op, input logic z,
                           output logic [7:0] rd, output logic [7:0] lir, output logic [7:0] ip,
                           output logic [7:0] ac, output logic [7:0] pc, output logic [7:0] wr,
                           output logic [7:0] de);
      logic [2:0] p;
      bit seen7;
      rd = '0; lir = '0; ip = '0; ac = '0; pc = '0; wr = '0; de = '0;
      waitPhase(3'd0);
      applyStimulus(op, z);
      seen7 = 1'b0;
      for (int k = 0; k < 24 && !seen7; k++) begin
         if (k != 0) @(negedge clk);
         else #1;
         p = phaseS;
         rd[p] = memRdS; lir[p] = loadIrS; ip[p] = incPcS; ac[p] = loadAcS;
         pc[p] = loadPcS; wr[p] = memWrS; de[p] = dataES;
         if (p == 3'd7) seen7 = 1'b1;
      end
      checkOutput("instr reaches phase 7", 32'(seen7), 32'd1);
      @(negedge clk);
      checkOutput("wrap 7->0", 32'(phaseS), 32'd0);
   endtask

   initial begin
      logic [7:0] rd, lir, ip, ac, pc, wr, de;
      int nz;
      numChecks = 0;
      numFails  = 0;
      checkEn   = 1'b0;
      autoStep  = 1'b0;
      step      = 1'b0;
      reset     = 1'b0;
      opcode    = OP_ADD;
      zero      = 1'b0;

      repeat (2) @(posedge clk);
      #1 checkEn = 1'b1;
      checkOutput("reset phase", 32'(phaseS), 32'd0);
      checkOutput("reset strobes",
                  32'({selS, memRdS, loadIrS, haltS, incPcS, loadAcS, loadPcS, memWrS, dataES}),
                  32'h100);
      @(negedge clk);
      #1 reset = 1'b1;

`ifdef VERIRISC_SEQ_SINGLE_STEP_EN
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("step hold at 0", 32'(phaseS), 32'd0);
      end
      #1 step = 1'b1;
      nz = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (phaseS != 3'd0) nz++;
         if (k == 0) #1 step = 1'b0;
      end
      checkOutput("one pass per step", 32'(nz), 32'd7);
      checkOutput("step ends at 0", 32'(phaseS), 32'd0);
      autoStep = 1'b1;
`else
      nz = 0;
`endif

      runInstr(OP_ADD, 1'b0, rd, lir, ip, ac, pc, wr, de);
      checkOutput("ADD mem_rd", 32'(rd), 32'h0EE);
      checkOutput("ADD load_ir", 32'(lir), 32'h00C);
      checkOutput("ADD inc_pc", 32'(ip), 32'h010);
      checkOutput("ADD load_ac", 32'(ac), 32'h080);
      checkOutput("ADD mem_wr", 32'(wr), 32'h000);

      runInstr(OP_SKZ, 1'b1, rd, lir, ip, ac, pc, wr, de);
      checkOutput("SKZ z=1 inc_pc", 32'(ip), 32'h050);
      runInstr(OP_SKZ, 1'b0, rd, lir, ip, ac, pc, wr, de);
      checkOutput("SKZ z=0 inc_pc", 32'(ip), 32'h010);

      runInstr(OP_STO, 1'b0, rd, lir, ip, ac, pc, wr, de);
      checkOutput("STO data_e", 32'(de), 32'h0C0);
      checkOutput("STO mem_wr", 32'(wr), 32'h080);
      checkOutput("STO load_ac", 32'(ac), 32'h000);

      runInstr(OP_JMP, 1'b0, rd, lir, ip, ac, pc, wr, de);
      checkOutput("JMP load_pc", 32'(pc), 32'h0C0);
      checkOutput("JMP inc_pc", 32'(ip), 32'h090);

      // Reset in the middle of a store must drop mem_wr without waiting for a clock.
      waitPhase(3'd0);
      applyStimulus(OP_STO, 1'b0);
      waitPhase(3'd7);
      checkOutput("STO mem_wr before reset", 32'(memWrS), 32'd1);
      #1 reset = 1'b0;
      #1;
      checkOutput("async reset mem_wr", 32'(memWrS), 32'd0);
      checkOutput("async reset phase", 32'(phaseS), 32'd0);
      checkOutput("async reset sel", 32'(selS), 32'd1);
      @(negedge clk);
      #1 reset = 1'b1;

      waitPhase(3'd0);
      applyStimulus(OP_HLT, 1'b0);
      waitPhase(3'd4);
      checkOutput("HLT halt in OP_ADDR", 32'(haltS), 32'd1);
      checkOutput("HLT inc_pc in OP_ADDR", 32'(incPcS), 32'd1);
      checkOutput("pulse halt in OP_ADDR", 32'(haltP), 32'd1);
      @(negedge clk);
      checkOutput("pulse continues to 5", 32'(phaseP), 32'd5);
      checkOutput("pulse halt drops", 32'(haltP), 32'd0);
      for (int k = 0; k < 20; k++) begin
         if (k != 0) @(negedge clk);
         checkOutput("halted phase", 32'(phaseS), 32'd4);
         checkOutput("halted halt", 32'(haltS), 32'd1);
         checkOutput("halted inc_pc", 32'(incPcS), 32'd0);
      end
      #1 reset = 1'b0;
      #1;
      checkOutput("halt reset phase", 32'(phaseS), 32'd0);
      checkOutput("halt reset strobes",
                  32'({selS, memRdS, loadIrS, haltS, incPcS, loadAcS, loadPcS, memWrS, dataES}),
                  32'h100);
      opcode = OP_ADD;
      @(negedge clk);
      #1 reset = 1'b1;
      waitPhase(3'd5);

      @(negedge clk);
      checkEn = 1'b0;
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/veririsc_sequencer.md
Name: veririsc_sequencer

Overview:
- Instruction-cycle controller for the VeriRISC datapath.
- Generates the 8-phase fetch/execute sequence and decodes the 3-bit opcode into control strobes for the PC counter, IR, accumulator, memory and address mux.
- Freezes on HLT until reset.
- Sits between the instruction register/ALU zero flag and the datapath enables.

Parameters:
- HALT_STICKY, 1: 1 = halted state held until reset; 0 = halt is a one-cycle pulse and the sequence continues.
- OPCODE_WIDTH, 3: opcode width; only 3 is supported, and elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous active-low reset.
- opcode  input  OPCODE_WIDTH  IR opcode field; sampled combinationally.
- zero  input  1  accumulator-zero flag.
- phase  output  3  current phase, 0..7.
- sel  output  1  address mux select (1 = PC, 0 = IR operand).
- mem_rd  output  1  memory read.
- load_ir  output  1  IR load enable.
- halt  output  1  halt indication.
- inc_pc  output  1  PC increment enable.
- load_ac  output  1  accumulator load enable.
- load_pc  output  1  PC load enable.
- mem_wr  output  1  memory write.
- data_e  output  1  accumulator-to-data-bus drive enable.

Behaviour:
- Reset: reset is asynchronous and active-low on a single clock, clk.
  - While reset = 0: phase = 0 (INST_ADDR), halted flag cleared.
  - All strobes decode from phase 0, so sel = 1 and every other output is 0.
- Phase register: 3-bit, advances +1 per clk rising edge when not halted. Wraps 7 -> 0 with no idle cycle.
- Opcodes (values 0..7): HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP.
- ALUOP = ADD | AND | XOR | LDA.
- Outputs are combinational from (phase, opcode, zero, halted). No output latency beyond the phase register.
- Strobes per phase (outputs not listed are 0):
  - INST_ADDR(0): sel = 1.
  - INST_FETCH(1): sel = 1, mem_rd = 1.
  - INST_LOAD(2): sel = 1, mem_rd = 1, load_ir = 1.
  - IDLE(3): sel = 1, mem_rd = 1, load_ir = 1.
  - OP_ADDR(4): inc_pc = 1; halt = (opcode == HLT).
  - OP_FETCH(5): mem_rd = ALUOP.
  - ALU_OP(6): mem_rd = ALUOP; inc_pc = SKZ & zero; load_pc = JMP; data_e = STO.
  - STORE(7): mem_rd = ALUOP; inc_pc = JMP; load_ac = ALUOP; load_pc = JMP; mem_wr = STO; data_e = STO.
- Halt, with HALT_STICKY = 1:
  - On the edge leaving OP_ADDR with opcode == HLT, set halted. Phase stays 4.
  - While halted: halt = 1, inc_pc forced 0, phase frozen, all other strobes 0.
  - Only reset clears halted.
- Halt, with HALT_STICKY = 0: halt asserts for the OP_ADDR cycle only; the sequence continues normally.
- opcode changes mid-instruction take effect immediately. Stability is the IR's job; no internal latch.
- zero is sampled only in ALU_OP.
- X on opcode outside phases 4..7 must not propagate to any output.
- Reset mid-instruction (any phase, including halted): immediate return to phase 0 with sel = 1 and all other strobes 0. No partial write: mem_wr drops asynchronously.

Optional Feature:
- Macro: VERIRISC_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Sequencer holds at phase 0 (outputs as INST_ADDR) until a rising edge of step, detected with a registered previous value that resets to 0.
  - Then runs phases 1..7 freely and stops at phase 0 again.
  - One instruction per step pulse. Halt rules are unchanged.
- Undefined: no step port; phase runs continuously.

Decomposition:
- Package veririsc_pkg:
  - opcode_t enum {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP}, 3 bits.
  - phase_t enum {INST_ADDR … STORE}, 3 bits.
  - Function is_aluop(opcode_t).
- Sub-module veririsc_phase_gen: 3-bit phase register with run enable, halted flag and optional step detection.
- The top level is pure decode.

Test Plan:
- Reset = 0 at t = 0, release -> phase = 0, sel = 1, all other strobes 0. Assert reset = 0 during phase 7 with opcode = STO -> mem_wr falls immediately and phase = 0.
- opcode = ADD, 8 clocks -> mem_rd = 1 in phases 1, 2, 3, 5, 6, 7; load_ir = 1 in 2–3; inc_pc = 1 in 4; load_ac = 1 in 7; mem_wr = 0 throughout; phase wraps 7 -> 0.
- opcode = SKZ, zero = 1 -> inc_pc = 1 in phases 4 and 6. Same with zero = 0 -> inc_pc only in phase 4.
- opcode = STO -> data_e = 1 in phases 6–7, mem_wr = 1 only in 7, load_ac = 0. opcode = JMP -> load_pc = 1 in phases 6–7, inc_pc = 1 in 7.
- opcode = HLT, HALT_STICKY = 1 -> phase stops at 4, halt = 1 and inc_pc = 0 for 20 clocks. Reset releases to phase 0. With HALT_STICKY = 0 -> halt = 1 for one cycle, phase reaches 5.
- VERIRISC_SEQ_SINGLE_STEP_EN with step held 0 for 10 clocks -> phase = 0 throughout. One step pulse -> exactly one 0->7->0 pass, then hold at 0.
